// File: rtl/ternary_operator.sv
// rtl/ternary_operator.sv - 2:1 operand selector with registered copy and select-toggle counter
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   a        in   WIDTH  operand chosen when s = 0
//   b        in   WIDTH  operand chosen when s = 1
//   s        in   1      select
//   en       in   1      load enable for the registered outputs
//   ot       out  WIDTH  combinational s ? b : a
//   ot_q     out  WIDTH  registered selection
//   s_q      out  1      select captured alongside ot_q
//   tgl_cnt  out  CNT_W  saturating count of registered select changes

module ternary_operator #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] ot,
    output logic [WIDTH-1:0] ot_q,
    output logic             s_q,
    output logic [CNT_W-1:0] tgl_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Zero-latency path; X/Z on s resolves with the ternary merge.
    assign ot = s ? b : a;

    always_ff @(posedge clk) begin
        if (rst) begin
            ot_q    <= '0;
            s_q     <= 1'b0;
            tgl_cnt <= '0;
        end else if (en) begin
            ot_q <= ot;
            s_q  <= s;
            // Compare against the previously captured select; since s_q
            // resets to 0, the first load with s = 1 counts as a toggle.
            if ((s != s_q) && (tgl_cnt != CNT_MAX)) begin
                tgl_cnt <= tgl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_operator.sv
// tb/tb_ternary_operator.sv - scoreboard bench for ternary_operator

module tb_ternary_operator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             en;
    logic [WIDTH-1:0] ot;
    logic [WIDTH-1:0] ot_q;
    logic             s_q;
    logic [CNT_W-1:0] tgl_cnt;

    ternary_operator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .s       (s),
        .en      (en),
        .ot      (ot),
        .ot_q    (ot_q),
        .s_q     (s_q),
        .tgl_cnt (tgl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] ot;
        logic [WIDTH-1:0] ot_q;
        logic             s_q;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    logic chk_valid = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Monitor: pops one expectation whenever the stimulus flags a sample point.
    always @(negedge clk) begin
        if (chk_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: sample requested but no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ot !== e.ot || ot_q !== e.ot_q || s_q !== e.s_q || tgl_cnt !== e.cnt) begin
                    fails++;
                    $display("FAIL %s: got ot=%h ot_q=%h s_q=%b cnt=%0d, want ot=%h ot_q=%h s_q=%b cnt=%0d",
                             e.name, ot, ot_q, s_q, tgl_cnt, e.ot, e.ot_q, e.s_q, e.cnt);
                end
            end
        end
    end

    // Apply inputs, clock once, queue the hand-computed expectation.
    task automatic step(input string name, input logic r, input logic e_n,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv,
                        input logic [WIDTH-1:0] x_ot, input logic [WIDTH-1:0] x_otq,
                        input logic x_sq, input logic [CNT_W-1:0] x_cnt);
        exp_t e;
        rst = r;
        en  = e_n;
        a   = av;
        b   = bv;
        s   = sv;
        @(posedge clk);
        #1;
        e.name = name;
        e.ot   = x_ot;
        e.ot_q = x_otq;
        e.s_q  = x_sq;
        e.cnt  = x_cnt;
        sb.push_back(e);
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with en=1, s=1, b=1: ot tracks, registers clear.
        step("reset_0", 1, 1, 8'h00, 8'h01, 1, 8'h01, 8'h00, 0, 2'd0);
        step("reset_1", 1, 1, 8'h00, 8'h01, 1, 8'h01, 8'h00, 0, 2'd0);

        // Combinational select with en=0, registers hold at reset values.
        step("comb_a1_s0", 0, 0, 8'h01, 8'h00, 0, 8'h01, 8'h00, 0, 2'd0);
        step("comb_b1_s1", 0, 0, 8'h00, 8'h01, 1, 8'h01, 8'h00, 0, 2'd0);
        step("comb_b0_s1", 0, 0, 8'h01, 8'h00, 1, 8'h00, 8'h00, 0, 2'd0);
        step("comb_a0_s0", 0, 0, 8'h00, 8'h01, 0, 8'h00, 8'h00, 0, 2'd0);

        // Registered load.
        step("load_s0", 0, 1, 8'h01, 8'h00, 0, 8'h01, 8'h01, 0, 2'd0);
        step("load_s1", 0, 1, 8'h01, 8'h01, 1, 8'h01, 8'h01, 1, 2'd1);

        // Enable low: registers hold while ot follows the inputs.
        step("hold_0", 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 1, 2'd1);
        step("hold_1", 0, 0, 8'h02, 8'h03, 1, 8'h03, 8'h01, 1, 2'd1);
        step("hold_2", 0, 0, 8'h04, 8'h05, 0, 8'h04, 8'h01, 1, 2'd1);
        step("hold_3", 0, 0, 8'h06, 8'h07, 1, 8'h07, 8'h01, 1, 2'd1);
        step("hold_4", 0, 0, 8'h08, 8'h09, 0, 8'h08, 8'h01, 1, 2'd1);

        // Toggle every cycle: counter climbs to 3 and sticks.
        step("sat_0", 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 2'd2);
        step("sat_1", 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 2'd3);
        step("sat_2", 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 2'd3);
        step("sat_3", 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 2'd3);
        step("sat_4", 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 2'd3);
        step("sat_5", 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 2'd3);

        // Full-width operands.
        step("w8_s0", 0, 1, 8'hA5, 8'h3C, 0, 8'hA5, 8'hA5, 0, 2'd3);
        step("w8_s1", 0, 1, 8'hA5, 8'h3C, 1, 8'h3C, 8'h3C, 1, 2'd3);

        // Reset mid-operation, then first load with s=1 counts as a toggle.
        step("midrst",      1, 1, 8'hA5, 8'h3C, 1, 8'h3C, 8'h00, 0, 2'd0);
        step("post_rst_s1", 0, 1, 8'hA5, 8'h3C, 1, 8'h3C, 8'h3C, 1, 2'd1);
        step("same_s1",     0, 1, 8'h5A, 8'hC3, 1, 8'hC3, 8'hC3, 1, 2'd1);

        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
